// File: rtl/image_window_capture_if.sv
// Avalon-MM register port and clk-domain pixel stream for image_window_capture.
interface image_window_capture_if #(
  parameter int PIX_W   = 8,
  parameter int COORD_W = 11
);
  logic [2:0]         addr;
  logic               rd_en;
  logic               wr_en;
  logic [31:0]        writedata;
  logic [31:0]        readdata;
  logic               pix_valid;
  logic [PIX_W-1:0]   pix_data;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               irq;

  modport master (
    output addr, rd_en, wr_en, writedata, pix_valid, pix_data, pix_x, pix_y,
    input  readdata, irq
  );

  modport slave (
    input  addr, rd_en, wr_en, writedata, pix_valid, pix_data, pix_x, pix_y,
    output readdata, irq
  );
endinterface

// File: rtl/image_window_capture.sv
// Captures a WIN_W x WIN_H window of the pixel stream into RAM, read back over Avalon-MM.
// Optional IMG_BLOCK_ADDR_EN adds 8x8 block-order read addressing (CTRL b4).
//
// state    | meaning
// IDLE     | not armed, pixels dropped
// WAIT_SOF | armed, waiting for the window origin pixel
// CAPTURE  | writing window pixels to RAM
// DONE     | window complete, held until re-arm (or one cycle if continuous)
module image_window_capture #(
  parameter int WIN_W    = 224,
  parameter int WIN_H    = 224,
  parameter int ORIGIN_X = 208,
  parameter int ORIGIN_Y = 128,
  parameter int PIX_W    = 8,
  parameter int COORD_W  = 11
) (
  input logic                  clk,
  input logic                  reset,
  image_window_capture_if.slave bus
);
  localparam int DEPTH = WIN_W * WIN_H;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [31:0] LAST_IDX = 32'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SOF = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_e;
  state_e state_q, state_d;

  logic        irq_en_q, cont_q, blk_mode;
  logic        done_q, done_d, short_q, short_d, aerr_q, aerr_d;
  logic [31:0] rdaddr_q, rdaddr_d, frame_cnt_q, frame_cnt_d, pix_cnt_q, pix_cnt_d;
  logic [31:0] readdata_q;
  logic        ram_we;
  logic [PIX_W-1:0] mem [DEPTH];

  logic ctrl_wr, stat_wr, arm, abort, rd_ram;
  assign ctrl_wr = bus.wr_en && (bus.addr == 3'd0);
  assign stat_wr = bus.wr_en && (bus.addr == 3'd1);
  assign arm     = ctrl_wr && bus.writedata[0];
  assign abort   = ctrl_wr && bus.writedata[3];
  assign rd_ram  = bus.rd_en && (bus.addr == 3'd3);

  logic in_win, at_origin, at_last;
  logic [COORD_W-1:0] dx, dy;
  logic [AW-1:0] wr_idx;
  assign in_win = bus.pix_valid
      && (bus.pix_x >= COORD_W'(ORIGIN_X)) && (bus.pix_x < COORD_W'(ORIGIN_X + WIN_W))
      && (bus.pix_y >= COORD_W'(ORIGIN_Y)) && (bus.pix_y < COORD_W'(ORIGIN_Y + WIN_H));
  assign at_origin = bus.pix_valid
      && (bus.pix_x == COORD_W'(ORIGIN_X)) && (bus.pix_y == COORD_W'(ORIGIN_Y));
  assign at_last = bus.pix_valid
      && (bus.pix_x == COORD_W'(ORIGIN_X + WIN_W - 1)) && (bus.pix_y == COORD_W'(ORIGIN_Y + WIN_H - 1));
  assign dx     = bus.pix_x - COORD_W'(ORIGIN_X);
  assign dy     = bus.pix_y - COORD_W'(ORIGIN_Y);
  assign wr_idx = AW'(32'(dy) * 32'(WIN_W) + 32'(dx));

  logic [31:0] rd_phys;
  logic        rd_oob;
  assign rd_oob = rdaddr_q > LAST_IDX;

`ifdef IMG_BLOCK_ADDR_EN
  localparam int BPR = WIN_W / 8;
  logic        blk_mode_q;
  logic [31:0] blk;
  assign blk_mode = blk_mode_q;
  assign blk      = {6'd0, rdaddr_q[31:6]};
  always_comb begin
    rd_phys = rdaddr_q;
    if (blk_mode_q)
      rd_phys = ((blk / 32'(BPR)) * 32'd8 + 32'(rdaddr_q[5:3])) * 32'(WIN_W)
              + (blk % 32'(BPR)) * 32'd8 + 32'(rdaddr_q[2:0]);
  end
`else
  assign blk_mode = 1'b0;
  assign rd_phys  = rdaddr_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.writedata[31:4], rd_phys[31:AW]};

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    short_d     = short_q;
    aerr_d      = aerr_q;
    pix_cnt_d   = pix_cnt_q;
    frame_cnt_d = frame_cnt_q;
    rdaddr_d    = rdaddr_q;
    ram_we      = 1'b0;
    if (stat_wr) begin
      if (bus.writedata[2]) done_d  = 1'b0;
      if (bus.writedata[3]) short_d = 1'b0;
      if (bus.writedata[4]) aerr_d  = 1'b0;
    end
    if (bus.wr_en && (bus.addr == 3'd2)) rdaddr_d = bus.writedata;
    else if (rd_ram) rdaddr_d = (rdaddr_q >= LAST_IDX) ? 32'd0 : rdaddr_q + 32'd1;
    if (rd_ram && rd_oob) aerr_d = 1'b1;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_d   = WAIT_SOF;
            done_d    = 1'b0;
            short_d   = 1'b0;
            pix_cnt_d = '0;
          end else if (state_q == DONE && cont_q) begin
            state_d = WAIT_SOF;
          end
        end
        WAIT_SOF: begin
          if (at_origin) begin
            state_d   = CAPTURE;
            ram_we    = 1'b1;
            pix_cnt_d = 32'd1;
          end
        end
        CAPTURE: begin
          // a repeated origin means the previous frame was short; restart from it
          if (at_origin) begin
            short_d   = 1'b1;
            ram_we    = 1'b1;
            pix_cnt_d = 32'd1;
          end else if (in_win) begin
            ram_we    = 1'b1;
            pix_cnt_d = pix_cnt_q + 32'd1;
            if (at_last) begin
              state_d     = DONE;
              done_d      = 1'b1;
              frame_cnt_d = frame_cnt_q + 32'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      irq_en_q    <= 1'b0;
      cont_q      <= 1'b0;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
      aerr_q      <= 1'b0;
      rdaddr_q    <= '0;
      frame_cnt_q <= '0;
      pix_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      short_q     <= short_d;
      aerr_q      <= aerr_d;
      rdaddr_q    <= rdaddr_d;
      frame_cnt_q <= frame_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      if (ctrl_wr) begin
        irq_en_q <= bus.writedata[1];
        cont_q   <= bus.writedata[2];
      end
    end
  end

`ifdef IMG_BLOCK_ADDR_EN
  always_ff @(posedge clk) begin
    if (reset) blk_mode_q <= 1'b0;
    else if (ctrl_wr) blk_mode_q <= bus.writedata[4];
  end
`endif

  // RAM is deliberately not reset
  always_ff @(posedge clk) begin
    if (ram_we && !reset) mem[wr_idx] <= bus.pix_data;
  end

  always_ff @(posedge clk) begin
    if (reset || !bus.rd_en) begin
      readdata_q <= '0;
    end else begin
      unique case (bus.addr)
        3'd0:    readdata_q <= {27'd0, blk_mode, 1'b0, cont_q, irq_en_q, 1'b0};
        3'd1:    readdata_q <= {27'd0, aerr_q, short_q, done_q, state_q};
        3'd2:    readdata_q <= rdaddr_q;
        3'd3:    readdata_q <= rd_oob ? 32'd0 : 32'(mem[rd_phys[AW-1:0]]);
        3'd4:    readdata_q <= frame_cnt_q;
        3'd5:    readdata_q <= pix_cnt_q;
        default: readdata_q <= '0;
      endcase
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = done_q & irq_en_q;
endmodule

// File: tb/tb_image_window_capture.sv
// Directed bench for image_window_capture on a 16x16 window at (4,2) in a 24x20 frame.
module tb_image_window_capture;
  localparam int WIN_W = 16, WIN_H = 16, OX = 4, OY = 2, FW = 24, FH = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  image_window_capture_if #(.PIX_W(8), .COORD_W(11)) bus ();

  image_window_capture #(
    .WIN_W(WIN_W), .WIN_H(WIN_H), .ORIGIN_X(OX), .ORIGIN_Y(OY), .PIX_W(8), .COORD_W(11)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_RW} op_e;
  typedef struct {
    op_e         op;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pv(input int x, input int y, input int seed);
    if (seed == 0) return 8'(x + y);
    return 8'(x * 3 + y * 17 + seed);
  endfunction

  task automatic px(input int x, input int y, input int seed);
    @(negedge clk);
    bus.rd_en     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.pix_valid = 1'b1;
    bus.pix_x     = 11'(x);
    bus.pix_y     = 11'(y);
    bus.pix_data  = pv(x, y, seed);
  endtask

  task automatic rows(input int y0, input int y1, input int seed);
    for (int y = y0; y < y1; y++)
      for (int x = 0; x < FW; x++) px(x, y, seed);
  endtask

  task automatic row_part(input int y, input int x0, input int x1, input int seed);
    for (int x = x0; x <= x1; x++) px(x, y, seed);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.rd_en     = 1'b0;
    bus.wr_en     = 1'b1;
    bus.addr      = a;
    bus.writedata = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rdwr(input logic [2:0] a, input logic do_wr, input logic [31:0] wd,
                      output logic [31:0] d);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.rd_en     = 1'b1;
    bus.wr_en     = do_wr;
    bus.addr      = a;
    bus.writedata = wd;
    @(negedge clk);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    d = bus.readdata;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    rdwr(a, 1'b0, 32'd0, d);
    check(name, d, exp);
  endtask

  task automatic idle_chk_irq(input logic exp, input string name);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    check(name, 32'(bus.irq), 32'(exp));
  endtask

  initial begin
    logic [31:0] d1, d2;
    bus.addr = '0; bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.writedata = '0;
    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.pix_x = '0; bus.pix_y = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_irq", 32'(bus.irq), 32'd0);
    reset = 1'b0;
    rd_chk(3'd0, 32'd0, "rst_ctrl");
    rd_chk(3'd1, 32'd0, "rst_status");
    rd_chk(3'd4, 32'd0, "rst_frame_cnt");
    rd_chk(3'd5, 32'd0, "rst_pix_cnt");
    @(negedge clk);
    check("rd_idle_zero", bus.readdata, 32'd0);

    // full frame, irq disabled
    wr(3'd0, 32'h1);
    rd_chk(3'd1, 32'h1, "t1_wait_sof");
    rows(0, FH, 0);
    idle_chk_irq(1'b0, "t1_irq_off");

    vt.push_back('{OP_RD, 3'd1, 32'd0,   32'h7,  "t1_status_done"});
    vt.push_back('{OP_RD, 3'd4, 32'd0,   32'd1,  "t1_frame_cnt"});
    vt.push_back('{OP_RD, 3'd5, 32'd0,   32'd256, "t1_pix_cnt"});
    vt.push_back('{OP_WR, 3'd2, 32'd0,   32'd0,  ""});
    vt.push_back('{OP_RD, 3'd3, 32'd0,   32'd6,  "t1_rddata0"});
    vt.push_back('{OP_RD, 3'd2, 32'd0,   32'd1,  "t1_rdaddr_inc"});
    vt.push_back('{OP_WR, 3'd2, 32'd255, 32'd0,  ""});
    vt.push_back('{OP_RD, 3'd3, 32'd0,   32'h24, "t2_rddata_last"});
    vt.push_back('{OP_RD, 3'd3, 32'd0,   32'd6,  "t2_rddata_wrap"});
    vt.push_back('{OP_RD, 3'd2, 32'd0,   32'd1,  "t2_rdaddr_after_wrap"});
    vt.push_back('{OP_WR, 3'd2, 32'd256, 32'd0,  ""});
    vt.push_back('{OP_RD, 3'd3, 32'd0,   32'd0,  "t2_rddata_oob"});
    vt.push_back('{OP_RD, 3'd1, 32'd0,   32'h17, "t2_status_addr_err"});
    vt.push_back('{OP_WR, 3'd1, 32'h10,  32'd0,  ""});
    vt.push_back('{OP_RD, 3'd1, 32'd0,   32'h7,  "t2_status_w1c"});
    vt.push_back('{OP_RW, 3'd2, 32'd40,  32'd0,  "t2_rdwr_old"});
    vt.push_back('{OP_RD, 3'd2, 32'd0,   32'd40, "t2_rdwr_new"});
    vt.push_back('{OP_RD, 3'd6, 32'd0,   32'd0,  "t2_addr6"});
    vt.push_back('{OP_RD, 3'd7, 32'd0,   32'd0,  "t2_addr7"});
    vt.push_back('{OP_RD, 3'd0, 32'd0,   32'd0,  "t2_ctrl"});
    vt.push_back('{OP_WR, 3'd0, 32'h2,   32'd0,  ""});
    vt.push_back('{OP_RD, 3'd0, 32'd0,   32'h2,  "t2_ctrl_irq_en"});
    for (int i = 0; i < vt.size(); i++) begin
      case (vt[i].op)
        OP_WR: wr(vt[i].a, vt[i].wd);
        OP_RD: rd_chk(vt[i].a, vt[i].exp, vt[i].name);
        default: begin
          rdwr(vt[i].a, 1'b1, vt[i].wd, d1);
          check(vt[i].name, d1, vt[i].exp);
        end
      endcase
    end
    idle_chk_irq(1'b1, "t1_irq_on");

`ifdef IMG_BLOCK_ADDR_EN
    wr(3'd0, 32'h12);
    rd_chk(3'd0, 32'h12, "t5_ctrl_blk");
    wr(3'd2, 32'd64);
    rd_chk(3'd3, 32'd14, "t5_blk64");
    rd_chk(3'd3, 32'd15, "t5_blk65");
    wr(3'd2, 32'd63);
    rd_chk(3'd3, 32'd20, "t5_blk63");
    wr(3'd2, 32'd137);
    rd_chk(3'd3, 32'd16, "t5_blk137");
`else
    wr(3'd0, 32'h12);
    rd_chk(3'd0, 32'h2, "t5_ctrl_noblk");
    wr(3'd2, 32'd64);
    rd_chk(3'd3, 32'd10, "t5_linear64");
`endif
    wr(3'd0, 32'h2);

    // short frame restart
    wr(3'd0, 32'h3);
    rd_chk(3'd1, 32'h1, "t3_armed");
    rd_chk(3'd5, 32'd0, "t3_pix_zero");
    idle_chk_irq(1'b0, "t3_irq_cleared");
    rows(0, 10, 5);
    row_part(2, 0, 4, 5);
    rd_chk(3'd1, 32'hA, "t3_short_capture");
    rd_chk(3'd5, 32'd1, "t3_pix_restart");
    row_part(2, 5, FW - 1, 5);
    rows(3, FH, 5);
    rd_chk(3'd1, 32'hF, "t3_done_short");
    rd_chk(3'd4, 32'd2, "t3_frame_cnt");
    rd_chk(3'd5, 32'd256, "t3_pix_cnt");
    idle_chk_irq(1'b1, "t3_irq");
    wr(3'd2, 32'd17);
    rd_chk(3'd3, 32'd71, "t3_rddata17");
    rd_chk(3'd3, 32'd74, "t3_rddata18");

    // continuous mode, then abort
    wr(3'd1, 32'h1C);
    rd_chk(3'd1, 32'h3, "t4_flags_cleared");
    wr(3'd0, 32'h5);
    rd_chk(3'd1, 32'h1, "t4_armed");
    rows(0, 17, 0);
    row_part(17, 0, 19, 0);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.rd_en = 1'b1;
    bus.addr  = 3'd1;
    @(negedge clk);
    d1 = bus.readdata;
    @(negedge clk);
    d2 = bus.readdata;
    bus.rd_en = 1'b0;
    check("t4_done_cycle", d1, 32'h7);
    check("t4_rearm_cycle", d2, 32'h5);
    row_part(17, 20, FW - 1, 0);
    rows(18, FH, 0);
    rows(0, FH, 0);
    rows(0, FH, 0);
    rd_chk(3'd4, 32'd5, "t4_frame_cnt");
    rd_chk(3'd1, 32'h5, "t4_wait_sof");
    rows(0, 6, 0);
    rd_chk(3'd5, 32'd64, "t4_pix_mid");
    wr(3'd0, 32'h5);
    rd_chk(3'd1, 32'h6, "t4_arm_ignored");
    rd_chk(3'd5, 32'd64, "t4_pix_kept");
    wr(3'd0, 32'h8);
    rd_chk(3'd1, 32'h4, "t4_abort_idle");
    rd_chk(3'd4, 32'd5, "t4_frame_kept");
    wr(3'd0, 32'h9);
    rd_chk(3'd1, 32'h4, "t4_abort_over_arm");

    // reset mid-capture with a simultaneous arm
    wr(3'd0, 32'h7);
    rows(0, FH, 9);
    rows(0, 6, 9);
    idle_chk_irq(1'b1, "t6_irq_pre");
    rd_chk(3'd1, 32'h6, "t6_capture_pre");
    @(negedge clk);
    reset = 1'b1;
    bus.wr_en = 1'b1;
    bus.addr = 3'd0;
    bus.writedata = 32'h1;
    @(negedge clk);
    reset = 1'b0;
    bus.wr_en = 1'b0;
    check("t6_readdata", bus.readdata, 32'd0);
    check("t6_irq", 32'(bus.irq), 32'd0);
    rd_chk(3'd0, 32'd0, "t6_ctrl");
    rd_chk(3'd1, 32'd0, "t6_status");
    rd_chk(3'd2, 32'd0, "t6_rdaddr");
    rd_chk(3'd4, 32'd0, "t6_frame_cnt");
    rd_chk(3'd5, 32'd0, "t6_pix_cnt");
    rd_chk(3'd3, 32'd55, "t6_ram_kept");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
